// File: rtl/countdown_ctrl.sv
// countdown_ctrl: keypad-driven BCD countdown timer with an internal tick prescaler.
// Define COUNTDOWN_AUTO_RELOAD_EN to make DONE reload the amount and keep counting.
module countdown_ctrl #(
  parameter int DIGITS   = 2,
  parameter int TICK_DIV = 100000000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                key_start,
  input  logic                key_confirm,
  input  logic                key_clear,
  input  logic                key_num,
  input  logic [3:0]          num,
  output logic                display_en,
  output logic [4*DIGITS-1:0] amount,
  output logic [4*DIGITS-1:0] remaining,
  output logic                running,
  output logic                paused,
  output logic                done_pulse
);
  localparam int AW = 4 * DIGITS;
  localparam int CW = $clog2(TICK_DIV);

  typedef enum logic [2:0] {S_IDLE, S_ENTRY, S_RUN, S_PAUSE, S_DONE} state_t;

  state_t        state_q;
  logic [3:0]    key_cur_q, key_prev_q;
  logic [AW-1:0] amount_q, remaining_q;
  logic [CW-1:0] cnt_q;
  logic          display_en_q, running_q, paused_q, done_q;

  logic [3:0]    rise_d;
  logic          ev_start_d, ev_clear_d, ev_confirm_d, ev_num_d;
  logic          tick_d, entry_ok_d;
  logic [CW-1:0] cnt_d;
  logic [AW-1:0] rem_dec_d, amount_ins_d;

  // BCD decrement by one; a zero digit borrows from the next and becomes 9.
  function automatic logic [AW-1:0] bcd_dec(input logic [AW-1:0] v);
    logic [AW-1:0] r;
    logic          borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Key order in the edge registers: {start, clear, confirm, num}.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_cur_q  <= '0;
      key_prev_q <= '0;
    end else begin
      key_cur_q  <= {key_start, key_clear, key_confirm, key_num};
      key_prev_q <= key_cur_q;
    end
  end

  always_comb begin
    rise_d       = key_cur_q & ~key_prev_q;
    ev_start_d   = rise_d[3];
    ev_clear_d   = rise_d[2] & ~rise_d[3];
    ev_confirm_d = rise_d[1] & ~(|rise_d[3:2]);
    ev_num_d     = rise_d[0] & ~(|rise_d[3:1]);
    tick_d       = (cnt_q == CW'(TICK_DIV - 1));
    cnt_d        = tick_d ? '0 : cnt_q + CW'(1);
    rem_dec_d    = bcd_dec(remaining_q);
    entry_ok_d   = (num <= 4'd9) && (amount_q[AW-1 -: 4] == 4'd0);
    amount_ins_d = (amount_q << 4) | AW'(num);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      display_en_q <= 1'b0;
      amount_q     <= '0;
      remaining_q  <= '0;
      cnt_q        <= '0;
      running_q    <= 1'b0;
      paused_q     <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (ev_start_d) begin
        amount_q    <= '0;
        remaining_q <= '0;
        cnt_q       <= '0;
        running_q   <= 1'b0;
        paused_q    <= 1'b0;
        if (state_q == S_IDLE) begin
          state_q      <= S_ENTRY;
          display_en_q <= 1'b1;
        end else begin
          state_q      <= S_IDLE;
          display_en_q <= 1'b0;
        end
      end else if (ev_clear_d && state_q != S_IDLE) begin
        state_q     <= S_ENTRY;
        amount_q    <= '0;
        remaining_q <= '0;
        cnt_q       <= '0;
        running_q   <= 1'b0;
        paused_q    <= 1'b0;
      end else begin
        case (state_q)
          S_ENTRY: begin
            if (ev_confirm_d) begin
              if (amount_q != '0) begin
                remaining_q <= amount_q;
                cnt_q       <= '0;
                state_q     <= S_RUN;
                running_q   <= 1'b1;
              end
            end else if (ev_num_d && entry_ok_d) begin
              amount_q <= amount_ins_d;
            end
          end
          // A confirm on a tick cycle wins: the counter holds and the tick is lost.
          S_RUN: begin
            if (ev_confirm_d) begin
              state_q   <= S_PAUSE;
              running_q <= 1'b0;
              paused_q  <= 1'b1;
            end else begin
              cnt_q <= cnt_d;
              if (tick_d) begin
                if (remaining_q == AW'(1)) begin
                  remaining_q <= '0;
                  done_q      <= 1'b1;
                  state_q     <= S_DONE;
                  running_q   <= 1'b0;
                end else begin
                  remaining_q <= rem_dec_d;
                end
              end
            end
          end
          S_PAUSE: begin
            if (ev_confirm_d) begin
              state_q   <= S_RUN;
              running_q <= 1'b1;
              paused_q  <= 1'b0;
            end
          end
          S_DONE: begin
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            cnt_q <= cnt_d;
            if (tick_d) begin
              remaining_q <= amount_q;
              state_q     <= S_RUN;
              running_q   <= 1'b1;
            end
`else
            cnt_q <= '0;
`endif
          end
          default: ;
        endcase
      end
    end
  end

  assign display_en = display_en_q;
  assign amount     = amount_q;
  assign remaining  = remaining_q;
  assign running    = running_q;
  assign paused     = paused_q;
  assign done_pulse = done_q;

endmodule

// File: tb/tb_countdown_ctrl.sv
// Scoreboard bench for countdown_ctrl (DIGITS=2, TICK_DIV=4): directed test-plan
// sequences plus random key traffic checked against an integer-level model.
`timescale 1ns/1ps
module tb_countdown_ctrl;
  localparam int DIGITS     = 2;
  localparam int TICK_DIV   = 4;
  localparam int AW         = 4 * DIGITS;
  localparam int OW         = 2 * AW + 4;
  localparam int LEAD_LIMIT = 10 ** (DIGITS - 1);
  localparam logic [3:0] K_START = 4'b1000;
  localparam logic [3:0] K_CLEAR = 4'b0100;
  localparam logic [3:0] K_CONF  = 4'b0010;
  localparam logic [3:0] K_NUM   = 4'b0001;
  localparam int M_IDLE = 0, M_ENTRY = 1, M_RUN = 2, M_PAUSE = 3, M_DONE = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          key_start = 1'b0, key_confirm = 1'b0, key_clear = 1'b0, key_num = 1'b0;
  logic [3:0]    num = 4'd0;
  logic          display_en, running, paused, done_pulse;
  logic [AW-1:0] amount, remaining;
  logic [OW-1:0] dut_outs;

  assign dut_outs = {display_en, amount, remaining, running, paused, done_pulse};

  typedef struct { int edge_n; logic [OW-1:0] outs; } exp_t;
  typedef struct { string nm; logic [31:0] act; logic [31:0] req; } dchk_t;

  exp_t       sb_q[$];
  dchk_t      dq[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         m_mode, m_amt, m_rem, m_phase;
  logic       m_done;
  logic [3:0] prev_keys;

  countdown_ctrl #(.DIGITS(DIGITS), .TICK_DIV(TICK_DIV)) dut (
    .clk(clk), .rst_n(rst_n),
    .key_start(key_start), .key_confirm(key_confirm), .key_clear(key_clear),
    .key_num(key_num), .num(num),
    .display_en(display_en), .amount(amount), .remaining(remaining),
    .running(running), .paused(paused), .done_pulse(done_pulse)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  function automatic logic [AW-1:0] to_bcd(input int v);
    logic [AW-1:0] r;
    int t;
    r = '0;
    t = v;
    for (int d = 0; d < DIGITS; d++) begin
      r[4*d +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic logic [OW-1:0] model_outs();
    return {m_mode != M_IDLE, to_bcd(m_amt), to_bcd(m_rem),
            m_mode == M_RUN, m_mode == M_PAUSE, m_done};
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_amt = 0; m_rem = 0; m_phase = 0; m_done = 1'b0;
    prev_keys = 4'b0;
  endtask

  // rise bits: [3]=start [2]=clear [1]=confirm [0]=num; highest bit wins.
  task automatic model_step(input logic [3:0] rise, input logic [3:0] nv);
    m_done = 1'b0;
    if (rise[3]) begin
      m_mode  = (m_mode == M_IDLE) ? M_ENTRY : M_IDLE;
      m_amt   = 0; m_rem = 0; m_phase = 0;
    end else if (m_mode == M_ENTRY) begin
      if (rise[2]) m_amt = 0;
      else if (rise[1]) begin
        if (m_amt != 0) begin m_rem = m_amt; m_phase = 0; m_mode = M_RUN; end
      end else if (rise[0]) begin
        if (nv <= 4'd9 && m_amt < LEAD_LIMIT) m_amt = m_amt * 10 + int'(nv);
      end
    end else if (m_mode != M_IDLE) begin
      if (rise[2]) begin
        m_mode = M_ENTRY; m_amt = 0; m_rem = 0; m_phase = 0;
      end else if (m_mode == M_PAUSE) begin
        if (rise[1]) m_mode = M_RUN;
      end else if (m_mode == M_RUN) begin
        if (rise[1]) m_mode = M_PAUSE;
        else begin
          m_phase++;
          if (m_phase == TICK_DIV) begin
            m_phase = 0;
            m_rem   = m_rem - 1;
            if (m_rem == 0) begin m_done = 1'b1; m_mode = M_DONE; end
          end
        end
      end else begin
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        m_phase++;
        if (m_phase == TICK_DIV) begin m_phase = 0; m_rem = m_amt; m_mode = M_RUN; end
`endif
      end
    end
  endtask

  task automatic dcheck(input string nm, input logic [31:0] act, input logic [31:0] req);
    dchk_t d;
    d.nm = nm; d.act = act; d.req = req;
    dq.push_back(d);
  endtask

  // One clock of stimulus; the key edge reaches the outputs two edges later.
  task automatic cycle(input logic [3:0] keys, input logic [3:0] nv);
    exp_t e;
    @(posedge clk);
    #1;
    {key_start, key_clear, key_confirm, key_num} = keys;
    num = nv;
    model_step(keys & ~prev_keys, nv);
    prev_keys = keys;
    e.edge_n = cyc + 2;
    e.outs   = model_outs();
    sb_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(4'b0, num);
  endtask

  task automatic press(input logic [3:0] mask, input logic [3:0] nv, input int hold);
    for (int k = 0; k < hold; k++) cycle(mask, nv);
    cycle(4'b0, nv);
  endtask

  task automatic drain();
    for (int k = 0; k < 10 && sb_q.size() != 0; k++) @(posedge clk);
    if (sb_q.size() != 0) begin
      dcheck("sb_drain", 32'(sb_q.size()), 32'd0);
      sb_q.delete();
    end
  endtask

  task automatic do_reset();
    drain();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    {key_start, key_clear, key_confirm, key_num} = 4'b0;
    num = 4'd0;
    #1 dcheck("reset_async", 32'(dut_outs), 32'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    model_reset();
  endtask

  task automatic rand_seg(input int n_act);
    logic [3:0] mask, nv;
    int r;
    for (int a = 0; a < n_act; a++) begin
      r = int'($urandom_range(0, 99));
      if (r < 8)       mask = K_START;
      else if (r < 20) mask = K_CLEAR;
      else if (r < 42) mask = K_CONF;
      else if (r < 82) mask = K_NUM;
      else if (r < 92) mask = 4'($urandom_range(1, 15));
      else             mask = 4'b0;
      nv = num;
      if (mask[0]) nv = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(0, 9))
                                                   : 4'($urandom_range(10, 15));
      if (mask == 4'b0) idle(int'($urandom_range(10, 60)));
      else begin
        press(mask, nv, int'($urandom_range(1, 3)));
        idle(int'($urandom_range(0, 4)));
      end
    end
  endtask

  // Monitor: drains direct checks and compares the scoreboard entry due this edge.
  initial begin
    exp_t  e;
    dchk_t d;
    forever begin
      @(negedge clk);
      while (dq.size() != 0) begin
        d = dq.pop_front();
        checks++;
        if (d.act !== d.req) begin
          errors++;
          $display("FAIL %s: got 0x%0h, required 0x%0h", d.nm, d.act, d.req);
        end
      end
      if (rst_n && sb_q.size() != 0) begin
        if (sb_q[0].edge_n < cyc) begin
          e = sb_q.pop_front();
          checks++;
          errors++;
          $display("FAIL sb_lost: entry for edge %0d seen at edge %0d, required on time", e.edge_n, cyc);
        end else if (sb_q[0].edge_n == cyc) begin
          e = sb_q.pop_front();
          checks++;
          if (dut_outs !== e.outs) begin
            errors++;
            $display("FAIL sb_edge%0d: got en=%b amt=%h rem=%h run=%b pau=%b done=%b, required en=%b amt=%h rem=%h run=%b pau=%b done=%b",
                     cyc, display_en, amount, remaining, running, paused, done_pulse,
                     e.outs[OW-1], e.outs[OW-2 -: AW], e.outs[AW+2 -: AW],
                     e.outs[2], e.outs[1], e.outs[0]);
          end
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1 dcheck("reset_init", 32'(dut_outs), 32'd0);
    #3 rst_n = 1'b1;

    idle(30);
    press(K_START, 4'd0, 1);
    press(K_NUM, 4'd4, 1);
    press(K_NUM, 4'd2, 2);
    press(K_NUM, 4'd7, 1);
    idle(2);
    dcheck("amount_42", 32'(amount), 32'h42);
    press(K_CLEAR, 4'd7, 1);
    press(K_NUM, 4'd12, 1);
    idle(2);
    dcheck("num_gt9_ignored", 32'(amount), 32'h0);

    press(K_NUM, 4'd1, 1);
    press(K_NUM, 4'd0, 1);
    press(K_CONF, 4'd0, 1);
    idle(2);
    dcheck("run_10", 32'({running, remaining}), 32'h110);
    idle(45);
    dcheck("done_10", 32'({display_en, running, remaining}), 32'h200);

    press(K_CLEAR, 4'd0, 1);
    press(K_NUM, 4'd5, 1);
    press(K_CONF, 4'd5, 1);
    idle(6);
    press(K_CONF, 4'd5, 1);
    idle(20);
    dcheck("paused_04", 32'({paused, running, remaining}), 32'h204);
    press(K_CONF, 4'd5, 1);
    idle(3);

    cycle(K_START | K_CLEAR, 4'd5);
    for (int k = 0; k < 10; k++) cycle(K_START, 4'd5);
    idle(3);
    dcheck("start_wins_hold", 32'(dut_outs), 32'd0);

    press(K_START, 4'd0, 1);
    press(K_NUM, 4'd3, 1);
    press(K_NUM, 4'd5, 1);
    press(K_CONF, 4'd5, 1);
    idle(10);
    do_reset();
    idle(10);

    rand_seg(200);
    do_reset();
    rand_seg(200);
    do_reset();
    rand_seg(200);
    drain();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/countdown_ctrl.md
Name: countdown_ctrl

Overview:
- Parametrised successor to the countdown logic core.
- Single-clock countdown controller with keypad-driven BCD entry of N digits and an internal tick prescaler, replacing the separate tick clock.
- Adds pause/resume and a power toggle.
- Sits between the keypad scanner (key level inputs + num) and the display driver (BCD digits + enable).

Parameters:
- DIGITS, 2, number of BCD digits for both amount and remaining (1..8).
- TICK_DIV, 100000000, clk cycles per countdown tick (>=2); counter width $clog2(TICK_DIV).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- key_start  in  1  start/power key level (from keypad).
- key_confirm  in  1  confirm/pause key level.
- key_clear  in  1  clear key level.
- key_num  in  1  numeric key level.
- num  in  4  numeric key value; sampled on key_num rising edge.
- display_en  out  1  display enable.
- amount  out  4*DIGITS  entered value, BCD, digit 0 = LSD in bits [3:0].
- remaining  out  4*DIGITS  countdown value, BCD.
- running  out  1  high in RUN.
- paused  out  1  high in PAUSE.
- done_pulse  out  1  one-cycle pulse on reaching zero.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; display_en=0; amount=0; remaining=0; running=0; paused=0; done_pulse=0.
  - Tick counter=0; key edge registers=0.
- Key events:
  - Each key is registered once; an event is a rising edge (prev=0, cur=1). One event per press; holding a key produces nothing further.
  - Priority when several events occur in the same cycle: start > clear > confirm > num. Lower-priority events that cycle are dropped.
  - num is sampled in the same cycle as the key_num edge is detected.
- States:
  - IDLE:
    - start -> ENTRY, display_en=1, amount=0, remaining=0.
    - All other keys ignored.
  - ENTRY:
    - num: if num>9, ignore. If MSD of amount is nonzero (full), ignore. Otherwise amount = (amount shifted left one digit) | num.
    - clear: amount=0.
    - confirm: if amount==0, ignore. Otherwise remaining=amount, tick counter=0 -> RUN.
  - RUN:
    - Tick counter increments each cycle; at TICK_DIV-1 it wraps to 0 and a tick occurs.
    - On tick: remaining decrements by 1 in BCD, with per-digit borrow 0->9.
    - If remaining was 1 on that tick: remaining=0, done_pulse=1 for that one cycle -> DONE.
    - confirm -> PAUSE; tick counter holds its value.
  - PAUSE:
    - Counter frozen. confirm -> RUN; counting resumes from the held counter value.
  - DONE:
    - remaining held at 0; running=0.
  - From any of RUN/PAUSE/DONE:
    - clear -> ENTRY, amount=0, remaining=0, tick counter=0.
    - num ignored.
  - From any non-IDLE state: start -> IDLE; all outputs return to reset values except the edge registers.
- Simultaneous tick and key event: the key event is processed and the tick that cycle is discarded.
  - Example: confirm on a tick cycle pauses with remaining unchanged; the counter holds at TICK_DIV-1 and the next tick fires one cycle after resume.
- Output timing: all outputs are registered, so effects appear the cycle after the edge-detect cycle, giving 2 cycles from key rise to output change.
- Reset mid-RUN: immediate async return to IDLE; no done_pulse is generated.

Optional Feature:
- Macro: COUNTDOWN_AUTO_RELOAD_EN
- With the macro defined: DONE is transient.
  - On the next tick after entering DONE, remaining=amount and state returns to RUN (periodic timer).
  - done_pulse fires on every expiry.
  - clear/start behave as in RUN.
- Without the macro: DONE holds until a clear or start event.

Test Plan (DIGITS=2, TICK_DIV=4 unless noted):
- Reset released, no keys -> display_en=0, amount=0x00, remaining=0x00, running=0 indefinitely.
- start; num 4; num 2; num 7 -> amount=0x42; the third digit is ignored because the MSD is full. num 12 in a fresh entry is ignored.
- Enter 0x10, confirm -> running=1, remaining=0x10. After 4 cycles remaining=0x09 (BCD borrow). After 40 cycles total: remaining=0x00, done_pulse high exactly 1 cycle, running=0.
- Enter 0x05, confirm, wait 6 cycles, confirm -> paused=1, remaining=0x04 frozen for 20 cycles. confirm -> remaining=0x03 two cycles later (counter resumes at its held value).
- In RUN, assert key_start and key_clear in the same cycle -> start wins: IDLE, display_en=0, amount=remaining=0. Hold key_start high 10 cycles -> no further events.
- With COUNTDOWN_AUTO_RELOAD_EN, enter 0x02, confirm -> done_pulse at cycles 8, 20 and 32 after the RUN entry; remaining reloads to 0x02 each period.
